mmio_io_responder: RTL and testbench

- Memory-mapped I/O peripheral that answers the single-cycle RISC-V core's data-port accesses in the 0x0200_0000 window.
- It is the responder side of the stores that the top level and the bench monitor. It holds the LED register, a free-running cycle counter, a sticky completion register, and a byte output FIFO.
- The FIFO drains over a valid/ready stream toward a host, console or bench.
- The block sits beside dmem; the core's data-address decode routes window hits here.

---
 rtl/mmio_io_responder.sv | 78 +++++++
 tb/tb_mmio_io_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: MMIO window with LED, cycle counter, sticky done and a byte TX FIFO.
module mmio_io_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic [7:0]  led,
  output logic        done,
  output logic [7:0]  done_code,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow, r_done;
  logic [7:0]         r_led, r_done_code;
  logic [31:0]        r_cycle;
  logic [5:0]         w_off;
  logic               w_we, w_empty, w_full, w_pop, w_push_req, w_push, w_unused;
  logic [31:0]        w_status, w_rdata;
  assign hit        = DataAdr[31:8] == BASE_ADDR[31:8];
  assign w_off      = DataAdr[7:2];
  assign w_we       = MemWrite && hit;
  assign w_empty    = r_count == '0;
  assign w_full     = r_count == (FIFO_AW+1)'(FIFO_DEPTH);
  assign w_pop      = tx_valid && tx_ready;
  assign w_push_req = w_we && w_off == 6'd4;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign tx_valid   = !w_empty;
  assign tx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign led        = r_led;
  assign done       = r_done;
  assign done_code  = r_done_code;
  assign w_status   = {16'b0, 8'(r_count), 5'b0, r_overflow, w_full, w_empty};
  assign w_rdata    = (w_off == 6'd0) ? {24'b0, r_led} :
                      (w_off == 6'd1) ? w_status :
                      (w_off == 6'd2) ? r_cycle :
                      (w_off == 6'd3) ? {23'b0, r_done, r_done_code} : 32'b0;
  assign ReadData   = hit ? w_rdata : 32'b0;
  assign w_unused   = ^{DataAdr[1:0], WriteData[31:8]};
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= WriteData[7:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_led       <= '0;
      r_done      <= 1'b0;
      r_done_code <= '0;
      r_cycle     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count <= r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
      // a dropped push outranks a same-cycle clear
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      else if (w_we && w_off == 6'd1 && WriteData[2]) r_overflow <= 1'b0;
      if (w_we && w_off == 6'd0) r_led <= WriteData[7:0];
      r_cycle <= (w_we && w_off == 6'd2) ? 32'd0 : r_cycle + 32'd1;
      if (w_we && w_off == 6'd3) begin
        r_done      <= 1'b1;
        r_done_code <= WriteData[7:0];
      end
    end
  end
endmodule

// File: tb/tb_mmio_io_responder.sv
// tb_mmio_io_responder: directed stimulus with a scoreboard for register reads and the TX stream.
module tb_mmio_io_responder;
  logic        clk = 0, reset = 0, MemWrite = 0, tx_ready = 0;
  logic [31:0] DataAdr = 0, WriteData = 0, ReadData;
  logic        hit, done, tx_valid;
  logic [7:0]  led, done_code, tx_data;
  logic        rd_req = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] rq[$];
  logic [7:0]  txq[$];
  logic        prev_hold = 0;
  logic [7:0]  prev_data = 0;
  localparam logic [31:0] LED = 32'h0200_0000, STAT = 32'h0200_0004, CYC = 32'h0200_0008,
                          DN = 32'h0200_000C, TX = 32'h0200_0010;

  mmio_io_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .ReadData(ReadData), .hit(hit), .led(led), .done(done), .done_code(done_code),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DataAdr = a; WriteData = d; MemWrite = 1;
    @(posedge clk); #1;
    MemWrite = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    DataAdr = a; rq.push_back(exp); rd_req = 1;
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: mid-cycle, compare reads and accepted TX bytes against the queues
  always @(negedge clk) begin
    if (rd_req) begin
      if (rq.size() == 0) chk("rd_queue_empty", 1, 0);
      else chk("read_data", ReadData, rq.pop_front());
    end
    if (prev_hold && tx_valid) chk("tx_hold_stable", {24'b0, tx_data}, {24'b0, prev_data});
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'b0, tx_data}, {24'b0, txq.pop_front()});
    end
    prev_hold = tx_valid && !tx_ready && reset;
    prev_data = tx_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_led", {24'b0, led}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    @(posedge clk); #1;
    reset = 1;
    idle(10);
    rd(CYC, 32'd10);
    wr(CYC, 32'h1234);
    rd(CYC, 32'd0);
    rd(CYC, 32'd1);
    wr(LED, 32'h0000_00A5);
    chk("led_a5", {24'b0, led}, 32'hA5);
    rd(LED, 32'hA5);
    rd(LED | 32'h3, 32'hA5);
    wr(32'h0300_0000, 32'h11);
    chk("miss_hit", {31'b0, hit}, 0);
    chk("led_kept", {24'b0, led}, 32'hA5);
    rd(32'h0300_0000, 0);
    rd(32'h0200_0020, 0);
    rd(TX, 0);
    rd(STAT, 32'h1);
    tx_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      wr(TX, i);
      txq.push_back(8'(i));
    end
    rd(STAT, 32'h1002);
    wr(TX, 32'h11);
    rd(STAT, 32'h1006);
    wr(STAT, 32'h4);
    rd(STAT, 32'h1002);
    tx_ready = 1;
    wr(TX, 32'h77);
    txq.push_back(8'h77);
    rd(STAT, 32'h1002);
    idle(15);
    rd(STAT, 32'h1);
    chk("drain_order", txq.size(), 0);
    for (int i = 0; i < 16; i++) begin
      tx_ready = i[0];
      wr(TX, 32'h10 + i);
      txq.push_back(8'(8'h10 + i));
    end
    tx_ready = 1;
    idle(20);
    rd(STAT, 32'h1);
    chk("toggle_all_seen", txq.size(), 0);
    wr(DN, 32'd55);
    chk("done_set", {31'b0, done}, 1);
    chk("done_code_37", {24'b0, done_code}, 32'h37);
    rd(DN, 32'h137);
    wr(DN, 32'd3);
    chk("done_sticky", {31'b0, done}, 1);
    chk("done_code_03", {24'b0, done_code}, 32'h03);
    rd(DN, 32'h103);
    tx_ready = 0;
    for (int i = 0; i < 5; i++) wr(TX, 32'hC0 + i);
    chk("queued_valid", {31'b0, tx_valid}, 1);
    chk("queued_head", {24'b0, tx_data}, 32'hC0);
    #2;
    reset = 0;
    #1;
    chk("async_tx_valid", {31'b0, tx_valid}, 0);
    chk("async_tx_data", {24'b0, tx_data}, 0);
    chk("async_done", {31'b0, done}, 0);
    chk("async_led", {24'b0, led}, 0);
    @(posedge clk); #1;
    reset = 1;
    rd(STAT, 32'h1);
    rd(DN, 32'h0);
    chk("rq_leftover", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
